// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared measurement FSM encoding and default counter sizing
// so the PWM generator and its capture block agree on width.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEASURE
    } state_t;

    localparam int unsigned PWM_WIDTH   = 16;
    localparam int unsigned PWM_TIMEOUT = 'hFFFF;

endpackage

// File: rtl/pwm_capture_sync_edge_detect.sv
// pwm_capture_sync_edge_detect: 2-flop synchronizer plus a third copy for
// rise/fall pulses; pulses come straight from flops, so no input-to-output path.
module pwm_capture_sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync <= '0;
        else        sync <= {sync[1:0], din};
    end

    assign level = sync[1];
    assign rise  = sync[1] & ~sync[2];
    assign fall  = ~sync[1] & sync[2];

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM line in clk
// cycles, strobes each result, and flags a line with no rising edge for TIMEOUT cycles.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned      WIDTH   = PWM_WIDTH,
    parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(PWM_TIMEOUT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pwmIn,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] active,
    output logic             valid,
    output logic             timeout,
    output logic             stuckHigh
);

    state_t state, state_next;
    logic level, rise, fall;
    logic start, capture, expire, measuring;
    logic [WIDTH-1:0] period_cnt, high_cnt, hold;

    pwm_capture_sync_edge_detect u_sync (
        .clk  (clk),
        .reset(reset),
        .din  (pwmIn),
        .level(level),
        .rise (rise),
        .fall (fall)
    );

    always_comb begin
        start      = enable && rise && state != IDLE;
        capture    = start && state == MEASURE;
        expire     = enable && state == MEASURE && !rise && period_cnt == TIMEOUT;
        measuring  = enable && state == MEASURE && !start && !expire;
        state_next = !enable ? IDLE : state == IDLE ? ARMED : start ? MEASURE : expire ? ARMED : state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // hold keeps the high count seen at the falling edge; it stays 0 if no fall occurred
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period     <= '0;
            active     <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            stuckHigh  <= 1'b0;
            period_cnt <= '0;
            high_cnt   <= '0;
            hold       <= '0;
        end else begin
            valid <= capture;
            if (capture) begin
                period  <= period_cnt;
                active  <= hold;
                timeout <= 1'b0;
            end
            if (!enable) begin
                timeout   <= 1'b0;
                stuckHigh <= 1'b0;
            end else if (expire) begin
                timeout   <= 1'b1;
                stuckHigh <= level;
            end
            period_cnt <= start ? WIDTH'(1) : measuring ? period_cnt + WIDTH'(1) : '0;
            high_cnt   <= start ? WIDTH'(1) : !measuring ? '0 : level ? high_cnt + WIDTH'(1) : high_cnt;
            hold       <= start ? '0 : !measuring ? '0 : fall ? high_cnt : hold;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and random PWM waveforms checked every cycle against a
// timestamp model (period = rise-to-rise, active = rise-to-fall, in clk edges).
module tb_pwm_capture;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        reset, enable, pwmIn;
    logic [15:0] period, active;
    logic        valid, timeout, stuckHigh;

    int checks = 0;
    int fails  = 0;

    // model: edge count, timestamps of the last detected rise/fall, recent input samples
    int          m_cyc       = 0;
    int          m_last_rise = -1;
    int          m_last_fall = -1;
    bit          m_warm      = 1'b0;
    logic [2:0]  m_hist      = '0;
    logic [15:0] exp_period  = '0;
    logic [15:0] exp_active  = '0;
    logic        exp_valid   = 1'b0;
    logic        exp_timeout = 1'b0;
    logic        exp_stuck   = 1'b0;

    pwm_capture #(.WIDTH(16), .TIMEOUT(16'(TMO))) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .pwmIn    (pwmIn),
        .period   (period),
        .active   (active),
        .valid    (valid),
        .timeout  (timeout),
        .stuckHigh(stuckHigh)
    );

    always #5 clk = ~clk;

    function automatic logic pat(input int i, input int hi, input int lo);
        return (i % (hi + lo)) < hi;
    endfunction

    // Drive one cycle at the negedge, advance the model at the posedge, return at the next negedge.
    // A level change sampled at edge e is seen by the measurement logic at edge e+2.
    task automatic tick(input logic p, input logic e);
        logic rise, fall;
        pwmIn = p;
        enable = e;
        @(posedge clk);
        m_cyc++;
        rise = m_hist[1] & ~m_hist[2];
        fall = ~m_hist[1] & m_hist[2];
        exp_valid = 1'b0;
        if (!reset) begin
            m_hist = '0;
            m_warm = 1'b0;
            m_last_rise = -1;
            m_last_fall = -1;
            exp_period = '0;
            exp_active = '0;
            exp_timeout = 1'b0;
            exp_stuck = 1'b0;
        end else begin
            if (!enable) begin
                exp_timeout = 1'b0;
                exp_stuck = 1'b0;
                m_warm = 1'b0;
                m_last_rise = -1;
            end else if (!m_warm) begin
                m_warm = 1'b1;
            end else if (rise) begin
                if (m_last_rise >= 0) begin
                    exp_valid = 1'b1;
                    exp_period = 16'(m_cyc - m_last_rise);
                    exp_active = m_last_fall > m_last_rise ? 16'(m_last_fall - m_last_rise) : 16'd0;
                    exp_timeout = 1'b0;
                end
                m_last_rise = m_cyc;
            end else if (m_last_rise >= 0 && m_cyc - m_last_rise >= TMO) begin
                exp_timeout = 1'b1;
                exp_stuck = m_hist[1];
                m_last_rise = -1;
            end
            if (fall) m_last_fall = m_cyc;
            m_hist = {m_hist[1:0], pwmIn};
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            tick(pat(i, 1, 1), 1'b1);
            checks++;
            if ({period, active, valid, timeout, stuckHigh} !== 35'd0) begin
                fails++;
                $display("FAIL reset i=%0d: got p=%0d a=%0d v=%b t=%b s=%b, want all 0", i, period, active, valid, timeout, stuckHigh);
            end
        end
        enable = 1'b0;
        tick(1'b0, 1'b0);
        reset = 1'b1;
        tick(1'b0, 1'b0);
    endtask

    task automatic test_basic();
        int nv = 0;
        int first_v = -1;
        for (int i = 0; i < 160; i++) begin
            tick(pat(i, 10, 10), 1'b1);
            checks++;
            if ({valid, timeout, stuckHigh, period, active} !== {exp_valid, exp_timeout, exp_stuck, exp_period, exp_active}) begin
                fails++;
                $display("FAIL basic i=%0d: got v=%b t=%b s=%b p=%0d a=%0d, want v=%b t=%b s=%b p=%0d a=%0d",
                         i, valid, timeout, stuckHigh, period, active, exp_valid, exp_timeout, exp_stuck, exp_period, exp_active);
            end
            if (valid) begin
                nv++;
                if (first_v < 0) first_v = i;
                checks++;
                if (period !== 16'd20 || active !== 16'd10) begin
                    fails++;
                    $display("FAIL basic_value i=%0d: got %0d/%0d, want 20/10", i, period, active);
                end
            end
        end
        checks++;
        if (first_v !== 22) begin
            fails++;
            $display("FAIL basic_latency: first valid at %0d, want 22", first_v);
        end
        checks++;
        if (nv !== 7) begin
            fails++;
            $display("FAIL basic_count: got %0d valids, want 7", nv);
        end
    endtask

    task automatic test_duty_switch();
        int nv = 0;
        for (int i = 0; i < 120; i++) begin
            tick(pat(i, 15, 5), 1'b1);
            checks++;
            if ({valid, timeout, stuckHigh, period, active} !== {exp_valid, exp_timeout, exp_stuck, exp_period, exp_active}) begin
                fails++;
                $display("FAIL duty i=%0d: got v=%b t=%b s=%b p=%0d a=%0d, want v=%b t=%b s=%b p=%0d a=%0d",
                         i, valid, timeout, stuckHigh, period, active, exp_valid, exp_timeout, exp_stuck, exp_period, exp_active);
            end
            if (valid) begin
                nv++;
                checks++;
                if (period !== 16'd20 || active !== (i < 20 ? 16'd10 : 16'd15)) begin
                    fails++;
                    $display("FAIL duty_value i=%0d: got %0d/%0d, want 20/%0d", i, period, active, i < 20 ? 10 : 15);
                end
            end
        end
        checks++;
        if (nv !== 6) begin
            fails++;
            $display("FAIL duty_count: got %0d valids, want 6", nv);
        end
    endtask

    task automatic test_timeout_low();
        int first_t = -1;
        for (int i = 0; i < 250; i++) begin
            tick(i < 60 ? pat(i, 10, 10) : i < 190 ? 1'b0 : pat(i - 190, 10, 10), 1'b1);
            checks++;
            if ({valid, timeout, stuckHigh, period, active} !== {exp_valid, exp_timeout, exp_stuck, exp_period, exp_active}) begin
                fails++;
                $display("FAIL tmo_low i=%0d: got v=%b t=%b s=%b p=%0d a=%0d, want v=%b t=%b s=%b p=%0d a=%0d",
                         i, valid, timeout, stuckHigh, period, active, exp_valid, exp_timeout, exp_stuck, exp_period, exp_active);
            end
            if (timeout && first_t < 0) first_t = i;
            if (i == 189) begin
                checks++;
                if ({timeout, stuckHigh, period, active} !== {1'b1, 1'b0, 16'd20, 16'd10}) begin
                    fails++;
                    $display("FAIL tmo_low_hold: got t=%b s=%b p=%0d a=%0d, want t=1 s=0 p=20 a=10", timeout, stuckHigh, period, active);
                end
            end
        end
        checks++;
        if (first_t !== 142) begin
            fails++;
            $display("FAIL tmo_low_time: timeout first at %0d, want 142", first_t);
        end
        checks++;
        if (timeout !== 1'b0) begin
            fails++;
            $display("FAIL tmo_low_clear: got timeout=%b, want 0", timeout);
        end
    endtask

    task automatic test_timeout_high();
        int next_v = -1;
        for (int i = 0; i < 180; i++) begin
            tick(i < 130 ? 1'b1 : ((i - 130) % 20) >= 10, 1'b1);
            checks++;
            if ({valid, timeout, stuckHigh, period, active} !== {exp_valid, exp_timeout, exp_stuck, exp_period, exp_active}) begin
                fails++;
                $display("FAIL tmo_high i=%0d: got v=%b t=%b s=%b p=%0d a=%0d, want v=%b t=%b s=%b p=%0d a=%0d",
                         i, valid, timeout, stuckHigh, period, active, exp_valid, exp_timeout, exp_stuck, exp_period, exp_active);
            end
            if (valid && i > 2 && next_v < 0) next_v = i;
            if (i == 129) begin
                checks++;
                if ({timeout, stuckHigh} !== 2'b11) begin
                    fails++;
                    $display("FAIL tmo_high_flag: got t=%b s=%b, want t=1 s=1", timeout, stuckHigh);
                end
            end
        end
        checks++;
        if (next_v !== 162 || period !== 16'd20 || active !== 16'd10) begin
            fails++;
            $display("FAIL tmo_high_rearm: valid at %0d with %0d/%0d, want 162 with 20/10", next_v, period, active);
        end
    endtask

    task automatic test_async_reset();
        int first_v = -1;
        for (int i = 0; i < 45; i++) begin
            tick(pat(i, 10, 10), 1'b1);
            checks++;
            if ({valid, timeout, stuckHigh, period, active} !== {exp_valid, exp_timeout, exp_stuck, exp_period, exp_active}) begin
                fails++;
                $display("FAIL areset_pre i=%0d: got v=%b t=%b s=%b p=%0d a=%0d, want v=%b t=%b s=%b p=%0d a=%0d",
                         i, valid, timeout, stuckHigh, period, active, exp_valid, exp_timeout, exp_stuck, exp_period, exp_active);
            end
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({period, active, valid, timeout, stuckHigh} !== 35'd0) begin
            fails++;
            $display("FAIL areset_now: got p=%0d a=%0d v=%b t=%b s=%b, want all 0", period, active, valid, timeout, stuckHigh);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(pat(i, 10, 10), 1'b1);
            checks++;
            if ({valid, timeout, stuckHigh, period, active} !== {exp_valid, exp_timeout, exp_stuck, exp_period, exp_active}) begin
                fails++;
                $display("FAIL areset_post i=%0d: got v=%b t=%b s=%b p=%0d a=%0d, want v=%b t=%b s=%b p=%0d a=%0d",
                         i, valid, timeout, stuckHigh, period, active, exp_valid, exp_timeout, exp_stuck, exp_period, exp_active);
            end
            if (valid && first_v < 0) first_v = i;
        end
        checks++;
        if (first_v !== 22) begin
            fails++;
            $display("FAIL areset_restart: first valid at %0d, want 22", first_v);
        end
    endtask

    task automatic test_enable_gap();
        int next_v = -1;
        for (int i = 0; i < 160; i++) begin
            tick(pat(i, 10, 10), !(i >= 45 && i < 50));
            checks++;
            if ({valid, timeout, stuckHigh, period, active} !== {exp_valid, exp_timeout, exp_stuck, exp_period, exp_active}) begin
                fails++;
                $display("FAIL en_gap i=%0d: got v=%b t=%b s=%b p=%0d a=%0d, want v=%b t=%b s=%b p=%0d a=%0d",
                         i, valid, timeout, stuckHigh, period, active, exp_valid, exp_timeout, exp_stuck, exp_period, exp_active);
            end
            if (valid && i > 42 && next_v < 0) next_v = i;
        end
        checks++;
        if (next_v !== 82 || period !== 16'd20 || active !== 16'd10 || timeout !== 1'b0) begin
            fails++;
            $display("FAIL en_gap_resume: valid at %0d with %0d/%0d t=%b, want 82 with 20/10 t=0", next_v, period, active, timeout);
        end
    endtask

    // period exactly TIMEOUT must still measure; then the 1-high/1-low minimum pulse
    task automatic test_boundary();
        for (int i = 0; i < 340; i++) begin
            tick(i < 300 ? pat(i, 50, 50) : pat(i - 300, 1, 1), 1'b1);
            checks++;
            if ({valid, timeout, stuckHigh, period, active} !== {exp_valid, exp_timeout, exp_stuck, exp_period, exp_active}) begin
                fails++;
                $display("FAIL bound i=%0d: got v=%b t=%b s=%b p=%0d a=%0d, want v=%b t=%b s=%b p=%0d a=%0d",
                         i, valid, timeout, stuckHigh, period, active, exp_valid, exp_timeout, exp_stuck, exp_period, exp_active);
            end
            if (valid) begin
                checks++;
                if ({period, active} !== (i < 100 ? {16'd20, 16'd10} : i <= 302 ? {16'd100, 16'd50} : {16'd2, 16'd1})) begin
                    fails++;
                    $display("FAIL bound_value i=%0d: got %0d/%0d", i, period, active);
                end
            end
            if (timeout) begin
                checks++;
                fails++;
                $display("FAIL bound_timeout i=%0d: got timeout=1, want 0", i);
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 150; s++) begin
            int hi = $urandom_range(1, 25);
            int lo = ($urandom_range(0, 7) == 0) ? $urandom_range(95, 130) : $urandom_range(1, 25);
            for (int k = 0; k < hi + lo; k++) begin
                tick(k < hi, 1'b1);
                checks++;
                if ({valid, timeout, stuckHigh, period, active} !== {exp_valid, exp_timeout, exp_stuck, exp_period, exp_active}) begin
                    fails++;
                    $display("FAIL random seg=%0d k=%0d: got v=%b t=%b s=%b p=%0d a=%0d, want v=%b t=%b s=%b p=%0d a=%0d",
                             s, k, valid, timeout, stuckHigh, period, active, exp_valid, exp_timeout, exp_stuck, exp_period, exp_active);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        enable = 1'b0;
        pwmIn = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_duty_switch();
        test_timeout_low();
        test_timeout_high();
        test_async_reset();
        test_enable_gap();
        test_boundary();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Downstream consumer of the PWM generator output. Samples an asynchronous PWM line and measures each full cycle in clk cycles: period (rising edge to rising edge) and active time (rising edge to falling edge). Publishes each measurement with a one-cycle valid strobe. Flags a stuck line (no rising edge within a timeout window) so loop-back checks and duty monitors can close the loop on the generator.

Parameters:
WIDTH, 16, width of counters and measurement outputs.
TIMEOUT, 16'hFFFF, cycles without a rising edge before timeout; must be ≤ 2^WIDTH-1 and ≥ 2.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
enable  input  1  measurement enable; low forces IDLE.
pwmIn  input  1  PWM line under measurement, asynchronous to clk.
period  output  WIDTH  last measured period in clk cycles.
active  output  WIDTH  last measured high time in clk cycles.
valid  output  1  one-cycle strobe; period/active updated this cycle.
timeout  output  1  level; no rising edge for TIMEOUT cycles.
stuckHigh  output  1  synchronized pwmIn level when timeout was raised.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, synchronizer flops 0, counters 0, state IDLE. Release is synchronous to clk.
- Input path: 2-flop synchronizer, then edge detect against a third registered copy. Edge-to-detect latency is 3 clk cycles, fixed, so it cancels in all measurements.
- States:
  - IDLE: counters held at 0. Go to ARMED when enable=1.
  - ARMED: wait for the first rising edge. Falling edges are ignored. On a rising edge: periodCnt=1, highCnt=1, go to MEASURE.
  - MEASURE: periodCnt increments every cycle. highCnt increments while the synced level is high and no falling edge has been seen since the last rise.
- Falling edge in MEASURE: capture highCnt into an internal hold register; highCnt freezes.
- Rising edge in MEASURE: period←periodCnt, active←held high count, valid=1 for exactly this cycle, timeout cleared. periodCnt and highCnt restart at 1, hold register cleared.
- Rising edge with no intervening falling edge (cannot occur after synchronization): active←0.
- Timeout: periodCnt reaches TIMEOUT with no rising edge in that cycle. Set timeout=1, stuckHigh←synced level, go to ARMED. period/active retain their last values.
- timeout is cleared by the next valid, or when enable goes low.
- Rising edge and timeout terminal count in the same cycle: the rising edge wins (valid, no timeout).
- enable falls in any state: go to IDLE next cycle; the in-progress measurement is discarded and valid is not asserted. period/active hold; timeout and stuckHigh clear.
- Reset mid-measurement: immediate clear. A fresh measurement needs two rising edges after release.
- Counters never wrap: TIMEOUT ≤ 2^WIDTH-1 guarantees timeout fires first.
- Outputs are all registered; there is no combinational path from inputs to outputs.
- Throughput: one measurement per PWM cycle. Minimum measurable pulse is 1 cycle high and 1 cycle low (period ≥ 2).

Decomposition:
- Shared package: state encoding (IDLE, ARMED, MEASURE) and default WIDTH/TIMEOUT constants, so the generator and this block agree on width.
- One natural sub-module: sync_edge_detect (2-flop synchronizer + rise/fall pulse outputs, async active-low reset). It is reusable for the start/stop inputs of the generator.

Test Plan:
1. reset pulse, enable=1, pwmIn driven 10 high / 10 low repeatedly → first valid 3 cycles after the second rising edge; period=20, active=10; valid every 20 cycles thereafter; timeout=0.
2. Mid-stream switch to 15 high / 5 low → the first fully new cycle reports period=20, active=15; the transition cycle reports a consistent pair with no glitch on valid.
3. TIMEOUT=100, pwmIn held low after one measurement → timeout=1 and stuckHigh=0 exactly 100 cycles after the last rising-edge detect; period/active hold 20/10. Resuming the PWM clears timeout on the next valid.
4. TIMEOUT=100, pwmIn held high → timeout=1, stuckHigh=1. A subsequent falling then rising edge does not assert valid until a second rising edge.
5. reset=0 asserted asynchronously (between clk edges) mid-measurement → all outputs 0 before the next clk edge. After release, no valid until two rising edges are seen.
6. enable dropped mid-cycle for 5 cycles then raised → no valid during or immediately after; period/active hold; the next valid comes after two fresh rising edges with correct 20/10.
